// File: rtl/capture_timer_pkg.sv
// Shared state encoding and saturation helper for the capture timer channels.
package capture_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Largest value representable in a counter of the given width.
  function automatic logic [31:0] cnt_max(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/capture_timer_channel.sv
// One interval-timer channel: counts from a start strobe to the next capture
// strobe, saturating at the counter maximum and latching the result.
module capture_timer_channel
  import capture_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 capture,
  input  logic                 rst_capture,
  output logic [CNT_WIDTH-1:0] value,
  output logic                 valid,
  output logic                 pulse,
  output logic                 running,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
    end
  end

  // Priority is clear, then capture, then start; capture beats a same-cycle start.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    pulse_d = 1'b0;
    if (rst_capture) begin
      state_d = ST_IDLE;
      count_d = '0;
      value_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            count_d = CNT_WIDTH'(1);
            ovf_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (capture) begin
            state_d = ST_DONE;
            value_d = count_q;
            pulse_d = 1'b1;
          end else if (start) begin
            count_d = CNT_WIDTH'(1);
            ovf_d   = 1'b0;
          end else if (count_q == CNT_MAX) begin
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            count_d = CNT_WIDTH'(1);
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign value    = value_q;
  assign valid    = (state_q == ST_DONE);
  assign running  = (state_q == ST_RUN);
  assign overflow = ovf_q;
  assign pulse    = pulse_q;

endmodule

// File: rtl/capture_timer.sv
// Multi-channel interval timer: NB_CAPTURES independent start/capture channels
// with packed result, status and strobe outputs.
module capture_timer
  import capture_timer_pkg::*;
#(
  parameter int NB_CAPTURES = 10,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_an_i,
  input  logic [NB_CAPTURES-1:0]           start_rise_i,
  input  logic [NB_CAPTURES-1:0]           capture_rise_i,
  input  logic [NB_CAPTURES-1:0]           rst_capture_rise_i,
  output logic [NB_CAPTURES*CNT_WIDTH-1:0] capture_value_o,
  output logic [NB_CAPTURES-1:0]           capture_valid_o,
  output logic [NB_CAPTURES-1:0]           capture_pulse_o,
  output logic [NB_CAPTURES-1:0]           running_o,
  output logic [NB_CAPTURES-1:0]           overflow_o
);

  for (genvar i = 0; i < NB_CAPTURES; i++) begin : g_ch
    capture_timer_channel #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_channel (
      .clk        (clk_i),
      .rst_n      (rst_an_i),
      .start      (start_rise_i[i]),
      .capture    (capture_rise_i[i]),
      .rst_capture(rst_capture_rise_i[i]),
      .value      (capture_value_o[i*CNT_WIDTH +: CNT_WIDTH]),
      .valid      (capture_valid_o[i]),
      .pulse      (capture_pulse_o[i]),
      .running    (running_o[i]),
      .overflow   (overflow_o[i])
    );
  end

endmodule

// File: doc/capture_timer.md
# capture_timer

Per-channel interval timer sitting directly downstream of the rising-edge detector. It consumes the one-cycle rising-edge strobes for start, capture and capture-reset, and measures the clock cycles between a start edge and the following capture edge on each of NB_CAPTURES independent channels. Each channel holds its result until it is re-armed or cleared. The latched value, valid flag, running flag, overflow flag and a one-cycle capture strobe go to the register/readout logic.

## Interface
- NB_CAPTURES, 10, number of independent channels; matches the edge detector.
- CNT_WIDTH, 16, width of each channel counter and captured value.

- clk_i  in  1  system clock; all logic on the rising edge.
- rst_an_i  in  1  asynchronous, active-low reset.
- start_rise_i  in  NB_CAPTURES  per-channel start strobe, one cycle wide.
- capture_rise_i  in  NB_CAPTURES  per-channel capture strobe, one cycle wide.
- rst_capture_rise_i  in  NB_CAPTURES  per-channel clear strobe, one cycle wide.
- capture_value_o  out  NB_CAPTURES*CNT_WIDTH  latched intervals; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- capture_valid_o  out  NB_CAPTURES  channel i holds a valid result (state DONE).
- capture_pulse_o  out  NB_CAPTURES  one-cycle strobe on the cycle after a value is latched.
- running_o  out  NB_CAPTURES  channel i is counting (state RUN).
- overflow_o  out  NB_CAPTURES  counter saturated during the current or last measurement.

## Operation
- Each channel runs a 3-state FSM: IDLE, RUN, DONE. Channels are fully independent.
- Per-cycle priority within a channel is rst_capture, then capture, then start.
- rst_capture in any state:
  - next state IDLE
  - counter, capture_value, overflow and pulse cleared
- IDLE:
  - start -> RUN, counter <= 1, overflow <= 0.
  - capture is ignored.
- RUN:
  - Each cycle, counter <= counter+1, saturating at 2^CNT_WIDTH-1.
  - Reaching saturation sets overflow; the counter holds.
  - capture -> DONE, capture_value <= current counter, pulse <= 1.
  - start without capture retriggers: counter <= 1, overflow <= 0, stays in RUN.
  - start and capture in the same cycle: capture wins and start is ignored.
- DONE:
  - capture_value and overflow hold.
  - start -> RUN, counter <= 1, overflow <= 0; capture_value is retained but valid drops.
  - capture is ignored.
- Resulting semantics: start sampled in cycle t and capture sampled in cycle t+N give capture_value = N, for 1 <= N <= 2^CNT_WIDTH-1.
  - Larger N latches 2^CNT_WIDTH-1 with overflow=1.
- Input strobes that last longer than one cycle are treated as repeated edges. The upstream block guarantees single-cycle strobes.

## Timing
- Reset values, all channels:
  - state IDLE
  - all outputs 0, including capture_value_o
- Asynchronous assertion, synchronous (clocked) deassertion behaviour: the first edge after release may already act on strobes.
- Outputs are registered and decoded from registered state only; there is no combinational path from input to output.
- Latency:
  - A strobe sampled at edge k is reflected in running_o/capture_valid_o/capture_value_o after edge k.
  - capture_pulse_o is high for exactly the cycle following edge k.
- running_o and capture_valid_o are never both 1 on a channel.
- Reset mid-measurement discards the count with no pulse.

## Structure
- Package capture_timer_pkg holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - a CNT_MAX helper function for saturation
- Sub-module capture_timer_channel implements one channel: FSM, counter, value register, flags.
- The top instantiates NB_CAPTURES copies of capture_timer_channel in a generate loop and packs their outputs.

## Test plan
- Reset: hold rst_an_i=0 with random strobes -> all outputs 0. Release, then start ch0 at cycle 5 and capture at cycle 15 -> value[0]=10, valid[0]=1, one pulse[0].
- Saturation (CNT_WIDTH=4): start, then capture 20 cycles later -> value=15, overflow=1, valid=1. A new start then clears overflow and running=1.
- Retrigger: start at 0, start at 7, capture at 12 -> value=5. Capture while IDLE or DONE -> no change and no pulse.
- Simultaneous events in RUN:
  - capture+start together -> DONE with the latched count.
  - rst_capture+capture together -> IDLE, value 0, no pulse.
- Reset mid-run: assert rst_an_i during RUN on 3 channels -> immediate zeros, including capture_value. After release a fresh measurement gives the correct N.
- Independence: interleave starts and captures across all 10 channels with distinct N (1..10). Each value[i] must be correct, and no channel is disturbed by another channel's strobes.
